// File: rtl/doa_pkg.sv
// doa_pkg: shared definitions for the direction-of-arrival peak search.
//   - default widths/sizes used as parameter defaults by the blocks
//   - scan FSM state encoding
package doa_pkg;

  localparam int DOA_WORD_LENGTH_IN = 71;
  localparam int DOA_NUM_ANGLES     = 181;
  localparam int DOA_ANGLE_WIDTH    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } doa_state_t;

endpackage

// File: rtl/doa_max_tracker.sv
// doa_max_tracker: running maximum / argmax over a stream of signed beats.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       forget the stored maximum; the next beat loads unconditionally
//   beat        value/index are valid this cycle
//   value       signed sample
//   index       index associated with the sample
//   max_value   maximum including the current beat (combinational view of the
//               register's next state, so the caller can capture the final
//               result on the same edge as the last beat)
//   max_index   index of max_value; ties keep the earliest index
module doa_max_tracker
  import doa_pkg::*;
#(
  parameter int W  = DOA_WORD_LENGTH_IN,
  parameter int AW = DOA_ANGLE_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 beat,
  input  logic signed [W-1:0]  value,
  input  logic        [AW-1:0] index,
  output logic signed [W-1:0]  max_value,
  output logic        [AW-1:0] max_index
);

  logic                 loaded_r;
  logic signed [W-1:0]  best_value_r;
  logic        [AW-1:0] best_index_r;
  logic                 take_s;

  // A beat replaces the stored maximum if nothing is stored yet or it is strictly larger
  always_comb begin
    take_s = 1'b0;
    if (beat) begin
      take_s = !loaded_r || (value > best_value_r);
    end else begin
      take_s = 1'b0;
    end
  end

  assign max_value = take_s ? value : best_value_r;
  assign max_index = take_s ? index : best_index_r;

  // Stored maximum register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded_r     <= 1'b0;
      best_value_r <= '0;
      best_index_r <= '0;
    end else if (clear) begin
      loaded_r     <= 1'b0;
      best_value_r <= '0;
      best_index_r <= '0;
    end else if (take_s) begin
      loaded_r     <= 1'b1;
      best_value_r <= value;
      best_index_r <= index;
    end
  end

endmodule

// File: rtl/doa_peak_search.sv
// doa_peak_search: steering-angle scan controller and beam-power peak detector.
// Issues angle indices 0..NUM_ANGLES-1 on start, receives the beam powers in
// issue order (any latency >= 1) and reports the strongest beam.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           scan request, honoured only in IDLE
//   angle_idx       steering-ROM address, angle_req qualifies it
//   power_in        signed beam power (non-negative), power_valid qualifies it
//   busy            scan in progress (includes the done cycle)
//   done            one-cycle result pulse
//   peak_idx        index of the strongest beam, held until the next done
//   peak_power      power of the strongest beam, held until the next done
// Optional build macro DOA_PEAK_THRESH_EN adds:
//   thresh          detection threshold, sampled on an accepted start
//   peak_found      peak_power >= thresh, updated with done
module doa_peak_search
  import doa_pkg::*;
#(
  parameter int WORD_LENGTH_IN = DOA_WORD_LENGTH_IN,
  parameter int NUM_ANGLES     = DOA_NUM_ANGLES,
  parameter int ANGLE_WIDTH    = DOA_ANGLE_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  output logic        [ANGLE_WIDTH-1:0]    angle_idx,
  output logic                             angle_req,
  input  logic signed [WORD_LENGTH_IN-1:0] power_in,
  input  logic                             power_valid,
  output logic                             busy,
  output logic                             done,
  output logic        [ANGLE_WIDTH-1:0]    peak_idx,
  output logic signed [WORD_LENGTH_IN-1:0] peak_power
`ifdef DOA_PEAK_THRESH_EN
  ,
  input  logic        [WORD_LENGTH_IN-1:0] thresh,
  output logic                             peak_found
`endif
);

  // One extra bit so the receive counter can represent NUM_ANGLES = 2^ANGLE_WIDTH
  localparam int CNT_W = ANGLE_WIDTH + 1;
  localparam logic [ANGLE_WIDTH-1:0] LAST_IDX = ANGLE_WIDTH'(NUM_ANGLES - 1);
  localparam logic [CNT_W-1:0]       LAST_RX  = CNT_W'(NUM_ANGLES - 1);

  doa_state_t                       state_r;
  logic        [CNT_W-1:0]          rx_cnt_r;
  logic                             accept_s;
  logic                             beat_s;
  logic                             last_beat_s;
  logic signed [WORD_LENGTH_IN-1:0] max_value_s;
  logic        [ANGLE_WIDTH-1:0]    max_index_s;
`ifdef DOA_PEAK_THRESH_EN
  logic        [WORD_LENGTH_IN-1:0] thresh_r;
`endif

  // Start acceptance and which power beats belong to the current scan
  always_comb begin
    accept_s    = 1'b0;
    beat_s      = 1'b0;
    last_beat_s = 1'b0;
    if (state_r == IDLE) begin
      accept_s = start;
    end else begin
      accept_s = 1'b0;
    end
    if ((state_r == ISSUE) || (state_r == WAIT)) begin
      beat_s = power_valid;
    end else begin
      beat_s = 1'b0;
    end
    last_beat_s = beat_s && (rx_cnt_r == LAST_RX);
  end

  // Beats arrive in issue order, so the receive count is the angle of the beat
  doa_max_tracker #(
    .W  (WORD_LENGTH_IN),
    .AW (ANGLE_WIDTH)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept_s),
    .beat      (beat_s),
    .value     (power_in),
    .index     (rx_cnt_r[ANGLE_WIDTH-1:0]),
    .max_value (max_value_s),
    .max_index (max_index_s)
  );

  // Scan FSM, issue/receive counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rx_cnt_r   <= '0;
      angle_idx  <= '0;
      angle_req  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      peak_idx   <= '0;
      peak_power <= '0;
`ifdef DOA_PEAK_THRESH_EN
      thresh_r   <= '0;
      peak_found <= 1'b0;
`endif
    end else begin
      if (beat_s) begin
        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= ISSUE;
            rx_cnt_r  <= '0;
            angle_idx <= '0;
            angle_req <= 1'b1;
            busy      <= 1'b1;
`ifdef DOA_PEAK_THRESH_EN
            thresh_r  <= thresh;
`endif
          end
        end
        ISSUE: begin
          if (angle_idx == LAST_IDX) begin
            angle_req <= 1'b0;
            state_r   <= WAIT;
          end else begin
            angle_idx <= angle_idx + ANGLE_WIDTH'(1);
          end
        end
        WAIT: begin
          // The tracker output already includes the last beat's compare
          if (last_beat_s) begin
            state_r    <= DONE;
            done       <= 1'b1;
            peak_idx   <= max_index_s;
            peak_power <= max_value_s;
`ifdef DOA_PEAK_THRESH_EN
            peak_found <= ($unsigned(max_value_s) >= thresh_r);
`endif
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          angle_req <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_doa_peak_search.sv
// tb_doa_peak_search: self-checking bench for doa_peak_search.
// A per-scan reference model pushes the expected result into a scoreboard
// queue at start; the result is popped and compared when done pulses.
// The power stage is emulated in-bench with configurable latency and gaps.
module tb_doa_peak_search;

  localparam int W  = 71;
  localparam int N  = 181;
  localparam int AW = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic        [AW-1:0] angle_idx;
  logic                 angle_req;
  logic signed [W-1:0]  power_in;
  logic                 power_valid;
  logic                 busy;
  logic                 done;
  logic        [AW-1:0] peak_idx;
  logic signed [W-1:0]  peak_power;
`ifdef DOA_PEAK_THRESH_EN
  logic        [W-1:0]  thresh;
  logic                 peak_found;
`endif

  typedef struct {
    logic        [AW-1:0] idx;
    logic signed [W-1:0]  pwr;
    logic                 found;
  } exp_t;

  exp_t                exp_q[$];
  logic signed [W-1:0] pw_tab[0:N-1];
  int                  errors = 0;
  int                  checks = 0;
  logic        [AW-1:0] held_idx = '0;
  logic signed [W-1:0]  held_pwr = '0;
  logic signed [W-1:0]  big;

  doa_peak_search dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .angle_idx   (angle_idx),
    .angle_req   (angle_req),
    .power_in    (power_in),
    .power_valid (power_valid),
    .busy        (busy),
    .done        (done),
    .peak_idx    (peak_idx),
    .peak_power  (peak_power)
`ifdef DOA_PEAK_THRESH_EN
    ,
    .thresh      (thresh),
    .peak_found  (peak_found)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: argmax with the lowest index winning ties
  task automatic push_expect();
    exp_t e;
    e.pwr = pw_tab[0];
    e.idx = '0;
    for (int i = 1; i < N; i++) begin
      if (pw_tab[i] > e.pwr) begin
        e.pwr = pw_tab[i];
        e.idx = AW'(i);
      end
    end
`ifdef DOA_PEAK_THRESH_EN
    e.found = ($unsigned(e.pwr) >= thresh);
`else
    e.found = 1'b1;
`endif
    exp_q.push_back(e);
  endtask

  task automatic fill_single_peak();
    for (int i = 0; i < N; i++) pw_tab[i] = 71'sd1000;
    pw_tab[37] = 71'sd5000000000000;
  endtask

  task automatic fill_random(input int hi);
    for (int i = 0; i < N; i++) pw_tab[i] = W'($urandom_range(0, hi));
  endtask

  // One scan with in-bench power stage; s1/s2 are cycles with stray start pulses
  task automatic run_scan(input string name, input int lat, input int maxgap,
                          input int s1, input int s2, input bit chk_time);
    int   due_q[$];
    int   id_q[$];
    int   last_due, cyc, nreq, nbeat, seq_err, ndone, due;
    bit   fin;
    exp_t e;
    push_expect();
    start = 1'b1;
    cyc = 0; last_due = 0; nreq = 0; nbeat = 0; seq_err = 0; ndone = 0; fin = 1'b0;
    for (int k = 0; k < 2000 && !fin; k++) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == s1) || (cyc == s2);
      power_valid = 1'b0;
      if (ndone > 0) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s after_done busy=%b done=%b want 0 0", name, busy, done);
        end
        fin = 1'b1;
      end else if (done === 1'b1) begin
        ndone++;
        e = exp_q.pop_front();
        checks += 5;
        if (peak_idx !== e.idx) begin
          errors++; $display("FAIL %s peak_idx got %0d want %0d", name, peak_idx, e.idx);
        end
        if (peak_power !== e.pwr) begin
          errors++; $display("FAIL %s peak_power got %0d want %0d", name, peak_power, e.pwr);
        end
        if (busy !== 1'b1) begin
          errors++; $display("FAIL %s busy_in_done got %b want 1", name, busy);
        end
        if (nbeat != N || nreq != N) begin
          errors++; $display("FAIL %s counts beats=%0d reqs=%0d want %0d", name, nbeat, nreq, N);
        end
        if (seq_err != 0) begin
          errors++; $display("FAIL %s scan_sequence got %0d bad cycles want 0", name, seq_err);
        end
        if (chk_time) begin
          checks++;
          if (cyc != N + 2) begin
            errors++; $display("FAIL %s done_cycle got %0d want %0d", name, cyc, N + 2);
          end
        end
`ifdef DOA_PEAK_THRESH_EN
        checks++;
        if (peak_found !== e.found) begin
          errors++; $display("FAIL %s peak_found got %b want %b", name, peak_found, e.found);
        end
`endif
        held_idx = e.idx;
        held_pwr = e.pwr;
      end else begin
        if (busy !== 1'b1) seq_err++;
        if (cyc == 1 && angle_req !== 1'b1) seq_err++;
        if (peak_idx !== held_idx || peak_power !== held_pwr) seq_err++;
        if (angle_req === 1'b1) begin
          if (angle_idx !== AW'(nreq)) seq_err++;
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          due += $urandom_range(0, maxgap);
          last_due = due;
          due_q.push_back(due);
          id_q.push_back(int'(angle_idx));
          nreq++;
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          power_valid = 1'b1;
          power_in = pw_tab[id_q.pop_front()];
          void'(due_q.pop_front());
          nbeat++;
        end
      end
    end
    start = 1'b0;
    power_valid = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s timeout done_seen=%0d beats=%0d want done", name, ndone, nbeat);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; power_valid = 1'b0; power_in = '0;
`ifdef DOA_PEAK_THRESH_EN
    thresh = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (angle_idx !== 8'd0 || angle_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        peak_idx !== 8'd0 || peak_power !== 71'sd0) begin
      errors++;
      $display("FAIL reset_values idx=%0d req=%b busy=%b done=%b pidx=%0d ppwr=%0d want all 0",
               angle_idx, angle_req, busy, done, peak_idx, peak_power);
    end
`ifdef DOA_PEAK_THRESH_EN
    checks++;
    if (peak_found !== 1'b0) begin
      errors++; $display("FAIL reset_peak_found got %b want 0", peak_found);
    end
`endif
  endtask

  task automatic test_single_peak();
    fill_single_peak();
    run_scan("single_peak", 1, 0, -1, -1, 1'b1);
  endtask

  task automatic test_tie_and_edges();
    fill_random(899);
    pw_tab[10] = 71'sd900;
    pw_tab[150] = 71'sd900;
    run_scan("tie", 1, 0, -1, -1, 1'b1);
    fill_random(1000000);
    pw_tab[0] = 71'sd2000000;
    run_scan("max_at_0", 1, 0, -1, -1, 1'b1);
    fill_random(1000000);
    pw_tab[180] = 71'sd2000000;
    run_scan("max_at_180", 1, 0, -1, -1, 1'b1);
  endtask

  task automatic test_var_latency();
    fill_single_peak();
    run_scan("var_latency", 5, 3, -1, -1, 1'b0);
  endtask

  task automatic test_ignored_start();
    fill_single_peak();
    run_scan("start_ignored", 1, 0, 90, N + 1, 1'b1);
  endtask

  task automatic test_idle_valid();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      power_valid = 1'b1;
      power_in = 71'sd9000000000000;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || angle_req !== 1'b0 ||
          peak_idx !== held_idx || peak_power !== held_pwr) begin
        errors++;
        $display("FAIL idle_valid done=%b busy=%b req=%b pidx=%0d ppwr=%0d want 0 0 0 %0d %0d",
                 done, busy, angle_req, peak_idx, peak_power, held_idx, held_pwr);
      end
    end
    @(posedge clk); #1;
    power_valid = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    logic          prev_req;
    logic [AW-1:0] prev_idx;
    bit            hit;
    fill_single_peak();
    start = 1'b1; prev_req = 1'b0; prev_idx = '0; hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      power_valid = prev_req;
      power_in = pw_tab[prev_idx];
      prev_req = angle_req;
      prev_idx = angle_idx;
      if (angle_req === 1'b1 && angle_idx === 8'd90) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL reset_mid_scan reach_angle_90 got none want angle 90");
    end
    rst_n = 1'b0;
    #1;
    held_idx = '0;
    held_pwr = '0;
    checks++;
    if (angle_idx !== 8'd0 || angle_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        peak_idx !== 8'd0 || peak_power !== 71'sd0) begin
      errors++;
      $display("FAIL reset_mid_scan idx=%0d req=%b busy=%b done=%b pidx=%0d ppwr=%0d want all 0",
               angle_idx, angle_req, busy, done, peak_idx, peak_power);
    end
    @(negedge clk) rst_n = 1'b1;
    // In-flight results arriving after reset must be dropped
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      power_valid = 1'b1;
      power_in = 71'sd7000000000000;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || angle_req !== 1'b0 || peak_idx !== 8'd0) begin
        errors++;
        $display("FAIL reset_inflight busy=%b done=%b req=%b pidx=%0d want 0 0 0 0",
                 busy, done, angle_req, peak_idx);
      end
    end
    @(posedge clk); #1;
    power_valid = 1'b0;
    run_scan("after_reset", 1, 0, -1, -1, 1'b1);
  endtask

`ifdef DOA_PEAK_THRESH_EN
  task automatic test_thresh();
    fill_single_peak();
    thresh = 71'd5000000000000;
    run_scan("thresh_equal", 1, 0, -1, -1, 1'b1);
    thresh = 71'd5000000000001;
    run_scan("thresh_above", 1, 0, -1, -1, 1'b1);
    thresh = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_peak();
    test_tie_and_edges();
    test_var_latency();
    test_ignored_start();
    test_idle_valid();
    test_reset_mid_scan();
`ifdef DOA_PEAK_THRESH_EN
    test_thresh();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/doa_peak_search.md
# doa_peak_search

Scan controller and peak detector that sits directly downstream of the 4-channel steering/abs-squared beamformer power stage. On `start` it sweeps the steering-angle index 0..NUM_ANGLES-1, which addresses the steering-vector ROM feeding the power stage. It receives the resulting beam powers in order and reports the angle index and power of the strongest beam. It is the final direction-of-arrival decision stage of the system.

## Interface
Parameters:
- `WORD_LENGTH_IN`, 71: width of the signed beam power from the power stage (2*(2*16+3)+1).
- `NUM_ANGLES`, 181: angles per scan (0..180 deg, 1 deg step); range 2..2^ANGLE_WIDTH.
- `ANGLE_WIDTH`, 8: width of angle index.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle scan request; honoured only in IDLE.
- `angle_idx`  out  ANGLE_WIDTH  steering-ROM address for the current request.
- `angle_req`  out  1  high for one cycle per issued angle.
- `power_in`  in  WORD_LENGTH_IN  signed beam power, always >= 0.
- `power_valid`  in  1  `power_in` valid; results arrive in issue order at any latency >= 1.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the scan result is valid.
- `peak_idx`  out  ANGLE_WIDTH  index of maximum power; held until next `done`.
- `peak_power`  out  WORD_LENGTH_IN  maximum power; held until next `done`.

## Operation
- FSM states:
  - IDLE -> ISSUE on `start`.
  - ISSUE -> WAIT after index NUM_ANGLES-1 is issued.
  - WAIT -> DONE when NUM_ANGLES results have been received.
  - DONE -> IDLE unconditionally.
- ISSUE: `angle_req`=1 every cycle with `angle_idx` counting from 0 to NUM_ANGLES-1. There is no backpressure.
- Receive counter `rx_cnt` counts `power_valid` beats in ISSUE and WAIT. Beats in IDLE or DONE are ignored.
- Running maximum:
  - On the first beat (`rx_cnt`=0) the tracker loads `power_in` and index 0 unconditionally.
  - On later beats it updates only when `power_in` > current max (strict signed compare).
  - Ties keep the lowest index.
- The beat with `rx_cnt`=NUM_ANGLES-1 is the last. Its compare is included in the result.
- `start` while not IDLE is ignored.
- `peak_idx`/`peak_power` outputs are copied from the tracker on entry to DONE. They do not change mid-scan.
- Reset (any state): FSM→IDLE, counters cleared, scan aborted. Results still in flight from the power stage arrive in IDLE and are dropped.

## Timing
- Reset values: `angle_idx`=0, `angle_req`=0, `busy`=0, `done`=0, `peak_idx`=0, `peak_power`=0.
- All outputs are registered.
- `start` in cycle T gives `angle_req`=1 with `angle_idx`=0 in T+1, and the last request in T+NUM_ANGLES. `busy` rises in T+1.
- Last `power_valid` in cycle L gives `done`=1 and updated peak outputs in L+1. `busy` falls in L+2, i.e. `busy`=1 during the `done` cycle.
- With the combinational power stage plus a 1-cycle ROM, the power latency is 1. Scan time is then NUM_ANGLES+2 cycles, start to done.
- A new `start` is accepted the cycle after `done`, with no dead cycles beyond IDLE.

## Configuration
- `DOA_PEAK_THRESH_EN` defined:
  - Adds input `thresh` (WORD_LENGTH_IN, unsigned interpretation of a non-negative value) and output `peak_found` (1 bit, reset 0).
  - `peak_found`=1, registered with `done`, iff final `peak_power` >= `thresh`.
  - `thresh` is sampled at accepted `start` and held for the scan.
- Not defined: ports absent, and the peak is always reported as valid.

## Structure
- Package `doa_pkg`:
  - FSM state enum {IDLE, ISSUE, WAIT, DONE}.
  - Default constants for WORD_LENGTH_IN, NUM_ANGLES, ANGLE_WIDTH.
- One sub-module, `doa_max_tracker`: clear, beat-valid, value/index in; running max/argmax out. Used for the running maximum.
- FSM and counters stay in the top.

## Test plan
- Single peak: latency-1 loopback, power = 1000 except index 37 = 5e12 -> `done` at cycle start+183, `peak_idx`=37, `peak_power`=5e12.
- Tie and edges:
  - Equal maxima 900 at indices 10 and 150 -> `peak_idx`=10.
  - Maximum at index 0 -> `peak_idx`=0.
  - Maximum at index 180 -> `peak_idx`=180.
- Variable latency:
  - Return latency 5 with random 0-3 cycle gaps between beats -> same result as the latency-1 run.
  - No spurious `done` before 181 beats.
- Ignored inputs:
  - `start` pulsed mid-ISSUE and in WAIT -> no restart, exactly one `done`.
  - `power_valid` in IDLE -> outputs unchanged.
- Reset mid-scan:
  - Assert `rst_n`=0 at angle 90 -> all outputs 0 at once, then IDLE.
  - A fresh scan then completes correctly.
- `DOA_PEAK_THRESH_EN`:
  - `thresh`=5e12 with peak 5e12 -> `peak_found`=1.
  - `thresh`=5e12+1 -> `peak_found`=0, with `peak_idx` still 37.
